// File: rtl/encode_serializer.sv
// 8b/10b transmit serializer: byte hold register, running-disparity encoder and a
// 10-bit LSB-first shifter, with a K28.1 comma burst for link-up and idle fill.
//   state  | meaning
//   LINKUP | sending the alignment comma burst, no bytes accepted
//   DATA   | sending held bytes, commas when idle
module encode_serializer #(
    parameter logic [7:0] COMMA_CHAR    = 8'h3C,
    parameter int         LINKUP_COMMAS = 16
) (
    input  logic       bitclk,
    input  logic       rst,
    input  logic [7:0] byteIn,
    input  logic       isKIn,
    input  logic       byteValid,
    output logic       byteReady,
    input  logic       resync,
    output logic       sigOut,
    output logic       wordStart,
    output logic       linkUp,
    output logic       kErr
);

    localparam int CW = $clog2(LINKUP_COMMAS + 1);

    typedef enum logic {LINKUP, DATA} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] comma_cnt, comma_cnt_nx;
    logic [9:0]    shreg;
    logic [3:0]    bit_cnt;
    logic          rd;
    logic [7:0]    hold_byte;
    logic          hold_k;
    logic          hold_full;
    logic          kerr_q;

    logic          take_hold, use_hold, load_kerr;
    logic [7:0]    enc_byte;
    logic          enc_k;
    logic [4:0]    enc_x;
    logic [2:0]    enc_y;
    logic [5:0]    c6, s6;
    logic [3:0]    c4, s4;
    logic          rd6, alt7, rd_nx;
    logic [9:0]    sym;
    logic          boundary;

    // 5b/6b codes in abcdei order, RD- column
    function automatic logic [5:0] code6(input logic [4:0] x);
        case (x)
            5'd0:    code6 = 6'b100111;
            5'd1:    code6 = 6'b011101;
            5'd2:    code6 = 6'b101101;
            5'd3:    code6 = 6'b110001;
            5'd4:    code6 = 6'b110101;
            5'd5:    code6 = 6'b101001;
            5'd6:    code6 = 6'b011001;
            5'd7:    code6 = 6'b111000;
            5'd8:    code6 = 6'b111001;
            5'd9:    code6 = 6'b100101;
            5'd10:   code6 = 6'b010101;
            5'd11:   code6 = 6'b110100;
            5'd12:   code6 = 6'b001101;
            5'd13:   code6 = 6'b101100;
            5'd14:   code6 = 6'b011100;
            5'd15:   code6 = 6'b010111;
            5'd16:   code6 = 6'b011011;
            5'd17:   code6 = 6'b100011;
            5'd18:   code6 = 6'b010011;
            5'd19:   code6 = 6'b110010;
            5'd20:   code6 = 6'b001011;
            5'd21:   code6 = 6'b101010;
            5'd22:   code6 = 6'b011010;
            5'd23:   code6 = 6'b111010;
            5'd24:   code6 = 6'b110011;
            5'd25:   code6 = 6'b100110;
            5'd26:   code6 = 6'b010110;
            5'd27:   code6 = 6'b110110;
            5'd28:   code6 = 6'b001110;
            5'd29:   code6 = 6'b101110;
            5'd30:   code6 = 6'b011110;
            default: code6 = 6'b101011;
        endcase
    endfunction

    function automatic logic [3:0] code4_d(input logic [2:0] y, input logic a7);
        case (y)
            3'd0:    code4_d = 4'b1011;
            3'd1:    code4_d = 4'b1001;
            3'd2:    code4_d = 4'b0101;
            3'd3:    code4_d = 4'b1100;
            3'd4:    code4_d = 4'b1101;
            3'd5:    code4_d = 4'b1010;
            3'd6:    code4_d = 4'b0110;
            default: code4_d = a7 ? 4'b0111 : 4'b1110;
        endcase
    endfunction

    function automatic logic [3:0] code4_k(input logic [2:0] y);
        case (y)
            3'd0:    code4_k = 4'b1011;
            3'd1:    code4_k = 4'b0110;
            3'd2:    code4_k = 4'b1010;
            3'd3:    code4_k = 4'b1100;
            3'd4:    code4_k = 4'b1101;
            3'd5:    code4_k = 4'b0101;
            3'd6:    code4_k = 4'b1001;
            default: code4_k = 4'b0111;
        endcase
    endfunction

    function automatic logic k_valid(input logic [7:0] b);
        k_valid = (b[4:0] == 5'd28) ||
                  ((b[7:5] == 3'd7) && (b[4:0] == 5'd23 || b[4:0] == 5'd27 ||
                                        b[4:0] == 5'd29 || b[4:0] == 5'd30));
    endfunction

    assign boundary  = (bit_cnt == 4'd9);
    assign linkUp    = (state == DATA);
    assign byteReady = linkUp & ~hold_full;
    assign sigOut    = shreg[0];
    assign wordStart = (bit_cnt == 4'd0);
    assign kErr      = kerr_q;

    always_comb begin
        state_nx     = state;
        comma_cnt_nx = comma_cnt;
        take_hold    = 1'b0;
        use_hold     = 1'b0;
        load_kerr    = 1'b0;
        case (state)
            LINKUP: begin
                comma_cnt_nx = comma_cnt + CW'(1);
                if (comma_cnt == CW'(LINKUP_COMMAS - 1))
                    state_nx = DATA;
            end
            DATA: begin
                if (resync) begin
                    state_nx     = LINKUP;
                    comma_cnt_nx = '0;
                end else if (hold_full) begin
                    take_hold = 1'b1;
                    if (hold_k && !k_valid(hold_byte))
                        load_kerr = 1'b1;
                    else
                        use_hold = 1'b1;
                end
            end
        endcase
        enc_byte = use_hold ? hold_byte : COMMA_CHAR;
        enc_k    = use_hold ? hold_k : 1'b1;
    end

    // Each sub-block is stored as its RD- form and inverted at RD+ when it carries disparity
    always_comb begin
        enc_x = enc_byte[4:0];
        enc_y = enc_byte[7:5];
        c6 = (enc_k && enc_x == 5'd28) ? 6'b001111 : code6(enc_x);
        s6 = (rd && (($countones(c6) != 3) || (enc_x == 5'd7 && !enc_k))) ? ~c6 : c6;
        if ($countones(s6) > 3)
            rd6 = 1'b1;
        else if ($countones(s6) < 3)
            rd6 = 1'b0;
        else
            rd6 = rd;
        alt7 = (!rd6 && (enc_x == 5'd17 || enc_x == 5'd18 || enc_x == 5'd20)) ||
               ( rd6 && (enc_x == 5'd11 || enc_x == 5'd13 || enc_x == 5'd14));
        c4 = enc_k ? code4_k(enc_y) : code4_d(enc_y, alt7);
        s4 = (rd6 && (enc_k || ($countones(c4) != 2) || enc_y == 3'd3)) ? ~c4 : c4;
        if ($countones(s4) > 2)
            rd_nx = 1'b1;
        else if ($countones(s4) < 2)
            rd_nx = 1'b0;
        else
            rd_nx = rd6;
        sym = {s4[0], s4[1], s4[2], s4[3], s6[0], s6[1], s6[2], s6[3], s6[4], s6[5]};
    end

    always_ff @(posedge bitclk or posedge rst) begin
        if (rst) begin
            state     <= LINKUP;
            comma_cnt <= '0;
        end else if (boundary) begin
            state     <= state_nx;
            comma_cnt <= comma_cnt_nx;
        end
    end

    always_ff @(posedge bitclk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            bit_cnt   <= 4'd9;
            rd        <= 1'b0;
            kerr_q    <= 1'b0;
            hold_byte <= '0;
            hold_k    <= 1'b0;
            hold_full <= 1'b0;
        end else begin
            kerr_q <= 1'b0;
            if (boundary) begin
                shreg   <= sym;
                bit_cnt <= 4'd0;
                rd      <= rd_nx;
                kerr_q  <= load_kerr;
            end else begin
                shreg   <= {1'b0, shreg[9:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (boundary && take_hold) begin
                hold_full <= 1'b0;
            end else if (byteValid && byteReady) begin
                hold_full <= 1'b1;
                hold_byte <= byteIn;
                hold_k    <= isKIn;
            end
        end
    end

endmodule
